// File: rtl/fsb_ctl.sv
// fsb_ctl: 68000-style bus termination controller.
// Per-channel wait states, QoS hold-off and a timeout watchdog.
// nDTACK/nVPA/nBERR are registered and preset asynchronously while nAS is high.
//
// state  | meaning
// S_IDLE | no cycle in progress, waiting for nAS low
// S_WAIT | cycle started, counting wait states / timeout
// S_TERM | termination driven, waiting for nAS to rise
module fsb_ctl #(
  parameter int NCH     = 4,
  parameter int WSW     = 3,
  parameter int TOW     = 8,
  parameter int TIMEOUT = 128
) (
  input  logic               FCLK,
  input  logic               RESET,
  input  logic               nAS,
  input  logic [NCH-1:0]     CS,
  input  logic [NCH-1:0]     RDY,
  input  logic [NCH*WSW-1:0] WS,
  input  logic [NCH-1:0]     QOSMASK,
  input  logic               QoSEN,
  input  logic               EXTRDY,
  input  logic               IACKCS,
  input  logic               TOCLR,
  output logic               nDTACK,
  output logic               nVPA,
  output logic               nBERR,
  output logic               ASrf,
  output logic               BACT,
  output logic               BACTr,
  output logic               TOERR,
  output logic [2:0]         ERRCH
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

  state_t         r_state, w_state_nxt;
  logic [WSW-1:0] r_wcnt, w_wcnt_nxt;
  logic [TOW-1:0] r_tcnt, w_tcnt_nxt;
  logic           r_ndtack, r_nvpa, r_nberr;

  logic [2:0]     w_sel;
  logic [WSW-1:0] w_ws_sel;
  logic           w_rdy_ch, w_qmask_ch;
  logic           w_cs_any, w_cs_multi, w_rdy;
  logic           w_ack, w_set_dtack, w_set_vpa, w_set_berr;
  logic [2:0]     w_err_ch;

  // Lowest selected channel and its per-channel fields; multi-hot detection.
  always_comb begin
    w_sel      = 3'd0;
    w_ws_sel   = '0;
    w_rdy_ch   = 1'b0;
    w_qmask_ch = 1'b0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (CS[i]) begin
        w_sel      = 3'(i);
        w_ws_sel   = WS[i*WSW +: WSW];
        w_rdy_ch   = RDY[i];
        w_qmask_ch = QOSMASK[i];
      end
    end
    w_cs_any   = |CS;
    w_cs_multi = |(CS & (CS - NCH'(1)));
    w_rdy      = (w_cs_any && w_rdy_ch && !(QoSEN && w_qmask_ch)) || EXTRDY;
    w_err_ch   = w_cs_any ? w_sel : 3'd7;
  end

  // Next-state, counters and termination requests.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_tcnt_nxt  = r_tcnt;
    w_ack       = 1'b0;
    w_set_berr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!nAS) begin
          if (w_cs_multi) begin
            w_set_berr  = 1'b1;
            w_state_nxt = S_TERM;
          end else if ((w_ws_sel == '0 && w_rdy) || EXTRDY) begin
            w_ack       = 1'b1;
            w_state_nxt = S_TERM;
          end else begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = (w_cs_any && w_ws_sel != '0) ? w_ws_sel - WSW'(1) : '0;
            w_tcnt_nxt  = TOW'(1);
          end
        end
      end
      S_WAIT: begin
        if (nAS) begin
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
        end else if ((r_wcnt == '0 && w_rdy) || EXTRDY) begin
          w_ack       = 1'b1;
          w_state_nxt = S_TERM;
        end else if (r_tcnt == TOW'(TIMEOUT-1)) begin
          w_set_berr  = 1'b1;
          w_state_nxt = S_TERM;
        end else begin
          if (r_wcnt != '0) w_wcnt_nxt = r_wcnt - WSW'(1);
          w_tcnt_nxt = r_tcnt + TOW'(1);
        end
      end
      S_TERM: begin
        if (nAS) begin
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
        w_tcnt_nxt  = '0;
      end
    endcase
    w_set_vpa   = w_ack && IACKCS;
    w_set_dtack = w_ack && !IACKCS;
  end

  // State and counter registers.
  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // Terminations: set low on the terminating edge, preset high whenever nAS is high.
  always_ff @(posedge FCLK or posedge RESET or posedge nAS) begin
    if (RESET) begin
      r_ndtack <= 1'b1;
      r_nvpa   <= 1'b1;
      r_nberr  <= 1'b1;
    end else if (nAS) begin
      r_ndtack <= 1'b1;
      r_nvpa   <= 1'b1;
      r_nberr  <= 1'b1;
    end else begin
      if (w_set_dtack) r_ndtack <= 1'b0;
      if (w_set_vpa)   r_nvpa   <= 1'b0;
      if (w_set_berr)  r_nberr  <= 1'b0;
    end
  end

  // Sticky error flag; a new error on the same edge beats TOCLR.
  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      TOERR <= 1'b0;
      ERRCH <= 3'd0;
    end else if (w_set_berr) begin
      TOERR <= 1'b1;
      ERRCH <= w_err_ch;
    end else if (TOCLR) begin
      TOERR <= 1'b0;
    end
  end

  // Address strobe sampled on the falling edge.
  always_ff @(negedge FCLK or posedge RESET) begin
    if (RESET) ASrf <= 1'b0;
    else       ASrf <= !nAS;
  end

  // Bus-active registered on the rising edge.
  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) BACTr <= 1'b0;
    else       BACTr <= BACT;
  end

  assign BACT   = !nAS || ASrf;
  assign nDTACK = r_ndtack;
  assign nVPA   = r_nvpa;
  assign nBERR  = r_nberr;

endmodule

// File: tb/tb_fsb_ctl.sv
// tb_fsb_ctl: randomized bus cycles checked against an edge-count reference model.
module tb_fsb_ctl;
  localparam int NCH = 4, WSW = 3, TOW = 8, TIMEOUT = 128;
  localparam int NEVER = 100000;

  logic FCLK, RESET, nAS, QoSEN, EXTRDY, IACKCS, TOCLR;
  logic [NCH-1:0] CS, RDY, QOSMASK;
  logic [NCH*WSW-1:0] WS;
  logic nDTACK, nVPA, nBERR, ASrf, BACT, BACTr, TOERR;
  logic [2:0] ERRCH;

  fsb_ctl #(.NCH(NCH), .WSW(WSW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
    .FCLK(FCLK), .RESET(RESET), .nAS(nAS), .CS(CS), .RDY(RDY), .WS(WS),
    .QOSMASK(QOSMASK), .QoSEN(QoSEN), .EXTRDY(EXTRDY), .IACKCS(IACKCS), .TOCLR(TOCLR),
    .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR), .ASrf(ASrf), .BACT(BACT),
    .BACTr(BACTr), .TOERR(TOERR), .ERRCH(ERRCH));

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // current cycle description
  logic [3:0] c_cs, c_qmask;
  logic       c_one, c_multi, c_qos, c_iack;
  int         c_sel, c_ws, c_rdy_edge, c_ext_edge, c_qdrop;
  // model results
  int         m_edge;
  logic [2:0] m_pat;
  logic [2:0] m_ch;
  logic       m_toerr;
  logic [2:0] m_errch;

  function automatic logic [2:0] terms();
    return {nDTACK, nVPA, nBERR};
  endfunction

  // Reference: find the edge on which the cycle terminates and how.
  task automatic model_cycle(input logic [11:0] ws);
    bit found;
    c_one = ($countones(c_cs) == 1);
    c_multi = ($countones(c_cs) > 1);
    c_sel = 0;
    for (int i = NCH-1; i >= 0; i--) if (c_cs[i]) c_sel = i;
    c_ws = (c_cs != 0) ? int'(ws[c_sel*WSW +: WSW]) : 0;
    found = 0;
    m_ch = 3'd0;
    if (c_multi) begin
      m_edge = 1; m_pat = 3'b110; m_ch = 3'(c_sel); found = 1;
    end
    for (int k = 1; k <= TIMEOUT && !found; k++) begin
      bit gate, rdyk, extk;
      gate = c_qos && c_qmask[c_sel] && (c_qdrop == 0 || k < c_qdrop);
      rdyk = c_one && (k >= c_rdy_edge) && !gate;
      extk = (c_ext_edge != 0) && (k >= c_ext_edge);
      if ((rdyk && k >= c_ws + 1) || extk) begin
        m_edge = k; m_pat = c_iack ? 3'b101 : 3'b011; found = 1;
      end
    end
    if (!found) begin
      m_edge = TIMEOUT; m_pat = 3'b110; m_ch = c_one ? 3'(c_sel) : 3'd7;
    end
  endtask

  task automatic drive_inputs(input int k);
    logic [3:0] r;
    r = 4'($urandom);
    if (c_one) r[c_sel] = (k >= c_rdy_edge);
    RDY    = r;
    EXTRDY = (c_ext_edge != 0) && (k >= c_ext_edge);
    QoSEN  = c_qos && (c_qdrop == 0 || k < c_qdrop);
  endtask

  task automatic setup(input logic [3:0] cs, input logic [11:0] ws, input int rdy_edge,
                       input int ext_edge, input logic qos, input logic [3:0] qmask,
                       input int qdrop, input logic iack);
    c_cs = cs; c_rdy_edge = rdy_edge; c_ext_edge = ext_edge; c_qos = qos;
    c_qmask = qmask; c_qdrop = qdrop; c_iack = iack;
    model_cycle(ws);
    CS = cs; WS = ws; QOSMASK = qmask; IACKCS = iack;
    drive_inputs(1);
    nAS = 1'b0;
  endtask

  // Runs one cycle from posedge+1; ends at posedge+1.
  task automatic run_cycle(input logic [3:0] cs, input logic [11:0] ws, input int rdy_edge,
                           input int ext_edge, input logic qos, input logic [3:0] qmask,
                           input int qdrop, input logic iack, input int hold, input bit rel);
    setup(cs, ws, rdy_edge, ext_edge, qos, qmask, qdrop, iack);
    for (int k = 1; k <= m_edge + hold; k++) begin
      @(posedge FCLK); #1;
      if (k == m_edge && m_pat == 3'b110) begin
        m_toerr = 1'b1; m_errch = m_ch;
      end
      check_val($sformatf("term_e%0d", k), 32'(terms()), (k < m_edge) ? 32'h7 : 32'(m_pat));
      if (k == 1) check_val("asrf_bactr", {ASrf, BACTr}, 2'b11);
      if (k == m_edge) check_val("toerr_errch", {TOERR, ERRCH}, {m_toerr, m_errch});
      drive_inputs(k + 1);
    end
    if (rel) begin
      nAS = 1'b1;
      #1;
      check_val("async_release", 32'(terms()), 32'h7);
      check_val("bact_hold", 32'(BACT), 32'h1);
      @(posedge FCLK); #1;
      check_val("idle_bus", {BACT, BACTr, terms()}, 5'b00111);
      check_val("idle_toerr", {TOERR, ERRCH}, {m_toerr, m_errch});
    end
  endtask

  task automatic pulse_toclr();
    TOCLR = 1'b1;
    @(posedge FCLK); #1;
    TOCLR = 1'b0;
    m_toerr = 1'b0;
    check_val("toclr", 32'(TOERR), 32'(m_toerr));
  endtask

  initial begin
    logic [3:0] cs, qm;
    logic [11:0] ws;
    int mode, re, ee, qd, a, b;
    RESET = 1'b1; nAS = 1'b1; CS = '0; RDY = '0; WS = '0; QOSMASK = '0;
    QoSEN = 1'b0; EXTRDY = 1'b0; IACKCS = 1'b0; TOCLR = 1'b0;
    m_toerr = 1'b0; m_errch = 3'd0;
    repeat (2) @(posedge FCLK);
    #1;
    check_val("reset_state", {terms(), ASrf, BACTr, TOERR, ERRCH}, {3'b111, 1'b0, 1'b0, 1'b0, 3'd0});
    RESET = 1'b0;
    @(posedge FCLK); #1;

    // wait states: WS[1]=3 -> ack at edge 4
    run_cycle(4'b0010, 12'h018, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
    // interrupt acknowledge, zero wait states
    run_cycle(4'b0001, 12'h000, 1, 0, 0, 4'b0000, 0, 1, 1, 1);
    // timeout on channel 2, then clear
    run_cycle(4'b0100, 12'h0c0, NEVER, 0, 0, 4'b0000, 0, 0, 1, 1);
    pulse_toclr();
    // multi-hot select error
    run_cycle(4'b0011, 12'h000, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
    pulse_toclr();
    // QoS hold-off released before edge 5
    run_cycle(4'b1000, 12'h000, 1, 0, 1, 4'b1000, 5, 0, 1, 1);
    // ack on the very edge the timeout would fire
    run_cycle(4'b0100, 12'h000, TIMEOUT, 0, 0, 4'b0000, 0, 0, 0, 1);
    // no select, external ready
    run_cycle(4'b0000, 12'hfff, 1, 3, 0, 4'b0000, 0, 0, 1, 1);

    // abort in WAIT after edge 2
    setup(4'b0010, 12'h028, NEVER, 0, 0, 4'b0000, 0, 0);
    repeat (2) begin @(posedge FCLK); #1; check_val("abort_wait", 32'(terms()), 32'h7); end
    nAS = 1'b1;
    repeat (3) begin @(posedge FCLK); #1; check_val("abort_idle", {terms(), TOERR}, {3'b111, m_toerr}); end

    // reset while in TERM, then restart with nAS still low
    run_cycle(4'b0001, 12'h000, 1, 0, 0, 4'b0000, 0, 0, 1, 0);
    RESET = 1'b1;
    #1;
    m_toerr = 1'b0; m_errch = 3'd0;
    check_val("reset_term", {terms(), ASrf, BACTr, TOERR, ERRCH}, {3'b111, 1'b0, 1'b0, 1'b0, 3'd0});
    @(posedge FCLK); #1;
    check_val("reset_hold", 32'(terms()), 32'h7);
    RESET = 1'b0;
    @(posedge FCLK); #1;
    check_val("restart_ack", 32'(terms()), 32'h3);
    nAS = 1'b1;
    #1;
    check_val("restart_rel", 32'(terms()), 32'h7);
    @(posedge FCLK); #1;

    // randomized cycles
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 9);
      ws = 12'($urandom);
      if (mode == 0) begin
        a = $urandom_range(0, 3); b = (a + $urandom_range(1, 3)) % 4;
        cs = 4'b0; cs[a] = 1'b1; cs[b] = 1'b1;
      end else if (mode == 1) begin
        cs = 4'b0;
      end else begin
        cs = 4'b0; cs[$urandom_range(0, 3)] = 1'b1;
      end
      re = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 8);
      ee = ($urandom_range(0, 3) == 0 || mode == 1) ? $urandom_range(1, 12) : 0;
      qm = 4'($urandom);
      qd = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 10) : 0;
      run_cycle(cs, ws, re, ee, 1'($urandom), qm, qd, 1'($urandom), $urandom_range(0, 2), 1);
      if ($urandom_range(0, 3) == 0) pulse_toclr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fsb_ctl.md
FSB_CTL -- requirements
Module: fsb_ctl

Interface
REQ-001 Parameter NCH, default 4: number of chip-select/ready channels (1..8).
REQ-002 Parameter WSW, default 3: width of per-channel wait-state field.
REQ-003 Parameter TOW, default 8: width of the timeout counter.
REQ-004 Parameter TIMEOUT, default 128: posedge count at which an unacknowledged cycle is bus-errored; SHALL be > 2^WSW and < 2^TOW.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Ports, one per line:
- FCLK  in  1  bus clock
- RESET  in  1  asynchronous active-high reset
- nAS  in  1  68000 address strobe, active low
- CS  in  NCH  one-hot channel selects
- RDY  in  NCH  per-channel ready
- WS  in  NCH*WSW  minimum wait states per channel; channel i at bits [i*WSW +: WSW]
- QOSMASK  in  NCH  channels gated while QoSEN high
- QoSEN  in  1  QoS hold-off enable
- EXTRDY  in  1  CS-independent ready; bypasses wait states and QoS
- IACKCS  in  1  interrupt-acknowledge cycle
- TOCLR  in  1  clears TOERR
- nDTACK, nVPA, nBERR  out  1 each  cycle terminations, active low
- ASrf  out  1  nAS low sampled on FCLK falling edge
- BACT  out  1  !nAS || ASrf, combinational
- BACTr  out  1  BACT registered on FCLK rising edge
- TOERR  out  1  sticky timeout/select-error flag
- ERRCH  out  3  CS-encoded channel of last error; 7 when no channel selected

Function
REQ-007 States IDLE, WAIT, TERM; all transitions on FCLK rising edge.
REQ-008 sel = channel with CS bit set; rdy = (CS[sel] && RDY[sel] && !(QoSEN && QOSMASK[sel])) || EXTRDY.
REQ-009 IDLE, nAS low, CS multi-hot: assert nBERR, set TOERR, ERRCH = lowest set index, go TERM.
REQ-010 IDLE, nAS low, (WS[sel]==0 && rdy) or EXTRDY: go TERM; assert nVPA if IACKCS, else nDTACK.
REQ-011 IDLE, nAS low, otherwise: go WAIT; WCNT = WS[sel]-1 (0 if WS[sel]==0 or CS zero); TCNT = 1.
REQ-012 WAIT, each edge: WCNT decrements to 0 and saturates; TCNT increments.
REQ-013 WAIT, WCNT==0 && rdy (or EXTRDY at any WCNT): terminate as REQ-010 and go TERM; with rdy held, ack falls on edge WS[sel]+1 counted from first nAS-low edge.
REQ-014 WAIT, TCNT reaches TIMEOUT-1 without ack: next edge asserts nBERR, sets TOERR, loads ERRCH, goes TERM; ack wins on the same edge.
REQ-015 nDTACK, nVPA, nBERR SHALL go high asynchronously while nAS is high (async preset), independent of FCLK.
REQ-016 TERM or WAIT with nAS high at an edge: go IDLE, clear WCNT/TCNT; aborted WAIT produces no termination and no error.
REQ-017 Exactly one of nDTACK/nVPA/nBERR SHALL be low at any time, at most.
REQ-018 CS, WS, IACKCS sampled every edge in WAIT; sel change mid-WAIT does not reload WCNT.
REQ-019 ASrf <= !nAS on FCLK falling edge; BACTr <= BACT on rising edge.
REQ-020 TOCLR high at an edge clears TOERR unless an error sets it on that edge (set wins).

Reset
REQ-021 RESET high SHALL force: state IDLE, nDTACK=nVPA=nBERR=1, ASrf=0, BACTr=0, WCNT=TCNT=0, TOERR=0, ERRCH=0; outputs hold until RESET low.
REQ-022 RESET asserted mid-cycle SHALL abort it; after release with nAS still low, the cycle restarts from IDLE on the next edge.

Verification
REQ-023 CS=0010, WS[1]=3, RDY[1]=1, nAS low -> nDTACK low at edge 4, high asynchronously when nAS rises.
REQ-024 CS=0001, WS[0]=0, RDY[0]=1, IACKCS=1 -> nVPA low at edge 1, nDTACK stays 1.
REQ-025 CS=0100, RDY=0, TIMEOUT=128 -> nBERR low at edge 128, TOERR=1, ERRCH=2; TOCLR pulse clears TOERR.
REQ-026 CS=0011 -> nBERR low at edge 1, ERRCH=0; QoSEN=1, QOSMASK=1000, CS=1000 RDY=1 -> no ack until QoSEN drops, then ack next edge.
REQ-027 nAS released in WAIT at edge 2 -> no termination, IDLE at next edge; RESET pulse during TERM -> all terminations 1 immediately.
